// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: shared controller state enum, opcodes and ALU encodings
package riscv_ctrl_pkg;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, ERROR
  } state_t;
  typedef enum logic [1:0] {ALUOP_ADD = 2'b00, ALUOP_SUB = 2'b01, ALUOP_FN = 2'b10} aluop_t;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps ALUOp/funct fields to the ALU operation code
module alu_decoder import riscv_ctrl_pkg::*; #(
  parameter int W = 3
) (
  input  aluop_t         ALUOp,
  input  logic [2:0]     funct3,
  input  logic           op5,
  input  logic           funct7b5,
  output logic [W-1:0]   ALUControl
);
  logic [2:0] code;
  always_comb begin
    code = ALU_ADD;
    if (ALUOp == ALUOP_SUB) code = ALU_SUB;
    else if (ALUOp == ALUOP_FN)
      case (funct3)
        3'b000:  code = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
        3'b010:  code = ALU_SLT;
        3'b110:  code = ALU_OR;
        3'b111:  code = ALU_AND;
        default: code = ALU_ADD;
      endcase
  end
  assign ALUControl = W'(code);
endmodule

// File: rtl/main_fsm.sv
// main_fsm: multicycle RISC-V Moore controller.
// Define ILLEGAL_INSTR_TRAP_EN to trap undefined opcodes in ERROR until reset.
module main_fsm import riscv_ctrl_pkg::*; #(
  parameter int ALUCTRL_W = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 Zero,
  output logic                 PCWrite,
  output logic                 AdrSrc,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 RegWrite,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ImmSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic                 IllegalInstr
);
  state_t state, next;
  aluop_t alu_op;
  logic pc_update, branch, mem_write, ir_write, reg_write;
  always_ff @(posedge clk) state <= reset ? FETCH : next;
  always_comb begin
    next = FETCH;
    pc_update = 1'b0;
    branch = 1'b0;
    mem_write = 1'b0;
    ir_write = 1'b0;
    reg_write = 1'b0;
    AdrSrc = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA = 2'b00;
    ALUSrcB = 2'b00;
    alu_op = ALUOP_ADD;
    IllegalInstr = 1'b0;
    case (state)
      FETCH: begin
        next = DECODE;
        ir_write = 1'b1;
        ALUSrcB = 2'b10;
        ResultSrc = 2'b10;
        pc_update = 1'b1;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: next = MEMADR;
          OP_R:         next = EXECR;
          OP_I:         next = EXECI;
          OP_BEQ:       next = BEQ;
          OP_JAL:       next = JAL;
`ifdef ILLEGAL_INSTR_TRAP_EN
          default:      next = ERROR;
`else
          default:      next = FETCH;
`endif
        endcase
      end
      MEMADR: begin
        next = (op == OP_LW) ? MEMREAD : MEMWRITE;
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      MEMREAD: begin
        next = MEMWB;
        AdrSrc = 1'b1;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        reg_write = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc = 1'b1;
        mem_write = 1'b1;
      end
      EXECR: begin
        next = ALUWB;
        ALUSrcA = 2'b10;
        alu_op = ALUOP_FN;
      end
      EXECI: begin
        next = ALUWB;
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op = ALUOP_FN;
      end
      ALUWB: reg_write = 1'b1;
      BEQ: begin
        ALUSrcA = 2'b10;
        alu_op = ALUOP_SUB;
        branch = 1'b1;
      end
      JAL: begin
        next = ALUWB;
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        pc_update = 1'b1;
      end
`ifdef ILLEGAL_INSTR_TRAP_EN
      ERROR: begin
        next = ERROR;
        IllegalInstr = 1'b1;
      end
`endif
      default: next = FETCH;
    endcase
  end
  // Strobes are gated by reset so a mid-instruction reset never commits a write.
  assign PCWrite  = ~reset & (pc_update | (branch & Zero));
  assign MemWrite = ~reset & mem_write;
  assign IRWrite  = ~reset & ir_write;
  assign RegWrite = ~reset & reg_write;
  assign ImmSrc = (op == OP_LW || op == OP_I) ? 2'b00 :
                  (op == OP_SW)  ? 2'b01 :
                  (op == OP_BEQ) ? 2'b10 :
                  (op == OP_JAL) ? 2'b11 : 2'b00;
  alu_decoder #(.W(ALUCTRL_W)) u_alu_dec (
    .ALUOp(alu_op),
    .funct3(funct3),
    .op5(op[5]),
    .funct7b5(funct7b5),
    .ALUControl(ALUControl)
  );
endmodule
